imem_fetch_ctrl: RTL and testbench

Instruction fetch controller that sequences the asynchronous-read instruction memory. It holds the fetch PC, drives the memory address, and captures each returned instruction with its PC into a small prefetch FIFO. Decode drains the FIFO through a valid/ready handshake. The block handles backpressure, branch/jump redirects with flush, and halt-opcode detection. It sits between the instruction memory and the decode stage of the CPU.

---
 rtl/imem_fetch_ctrl_if.sv | 27 ++
 rtl/imem_fetch_ctrl.sv | 75 +++++++
 tb/tb_imem_fetch_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-controller bus: instruction-memory port, redirect request and the
// decode-side valid/ready output stream.
interface imem_fetch_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  fetch_en;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_instr;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic                  out_ready;
    logic                  halted;

    modport master (
        input  fetch_en, imem_instr, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, halted
    );

    modport slave (
        output fetch_en, imem_instr, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, halted
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: walks fetch_pc over an async-read imem and
// queues {pc, instr} pairs in a small prefetch FIFO drained by decode.
module imem_fetch_ctrl #(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    FIFO_DEPTH  = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [3:0]            HALT_OPCODE = 4'h7
) (
    input logic                clk,
    input logic                rst,
    imem_fetch_ctrl_if.master  bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    entry_t                fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic                  halted_q;
    logic                  head_vld;
    logic                  pop;
    logic                  fetch;
    logic                  is_halt;

    assign head_vld = (count != '0);
    assign pop      = head_vld & bus.out_ready;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign fetch    = bus.fetch_en & ~halted_q & ~bus.redirect_valid &
                      ((count < DEPTH_C) | pop);
    assign is_halt  = (bus.imem_instr[DATA_WIDTH-1 -: 4] == HALT_OPCODE);

    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = head_vld;
    assign bus.out_pc    = head_vld ? fifo_mem[rd_ptr].pc    : '0;
    assign bus.out_instr = head_vld ? fifo_mem[rd_ptr].instr : '0;
    assign bus.halted    = halted_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            halted_q <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc;
            halted_q <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (fetch) begin
                wr_ptr   <= wr_ptr + PW'(1);
                fetch_pc <= fetch_pc + ADDR_WIDTH'(1);
                if (is_halt) halted_q <= 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(fetch) - CW'(pop);
        end
    end

    // Payload storage needs no reset; pointers and count gate its visibility.
    always_ff @(posedge clk) begin
        if (fetch) fifo_mem[wr_ptr] <= '{pc: fetch_pc, instr: bus.imem_instr};
    end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Scoreboard bench for imem_fetch_ctrl: stimulus queues expected {pc, instr}
// pops, a negedge monitor checks every decode handshake against the queue.
module tb_imem_fetch_ctrl;
    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [15:0] mem [256];
    logic [15:0] prog [16] = '{
        16'h2000, 16'h2101, 16'h2200, 16'h2301, 16'h3402, 16'h3503, 16'h4604, 16'h4705,
        16'h5806, 16'h5907, 16'h6A08, 16'h8B09, 16'hB102, 16'h1556, 16'hE008, 16'h7000
    };
    exp_t exp_q [$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imem_fetch_ctrl_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

    imem_fetch_ctrl #(
        .ADDR_WIDTH(8), .DATA_WIDTH(16), .FIFO_DEPTH(4),
        .RESET_PC(8'h00), .HALT_OPCODE(4'h7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.imem_instr = mem[bus.imem_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 256; i++) mem[i] = (i < 16) ? prog[i] : 16'h0000;
    endtask

    task automatic push_range(input logic [7:0] start, input int n);
        logic [7:0] p;
        for (int i = 0; i < n; i++) begin
            p = start + 8'(i);
            exp_q.push_back('{pc: p, instr: mem[p]});
        end
    endtask

    task automatic wait_halt_drain(input string name);
        int n = 0;
        while (!(bus.halted && !bus.out_valid) && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, 32'(n < 60), 32'd1);
        chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Every decode handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h want none", bus.out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("pop_pc", 32'(bus.out_pc), 32'(mon_e.pc));
                chk("pop_instr", 32'(bus.out_instr), 32'(mon_e.instr));
            end
        end
    end

    initial begin
        int n;
        load_prog();
        rst = 1'b1;
        bus.fetch_en = 1'b1;
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 8'h00;
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_imem_addr", 32'(bus.imem_addr), 32'd0);

        // Straight-line run to the halt opcode at pc 15.
        push_range(8'h00, 16);
        rst = 1'b0;
        tick();
        chk("first_valid", 32'(bus.out_valid), 32'd1);
        chk("first_pc", 32'(bus.out_pc), 32'd0);
        n = 0;
        while (!bus.halted && n < 40) begin tick(); n++; end
        chk("halt_seen", 32'(n < 40), 32'd1);
        chk("halt_head_pc", 32'(bus.out_pc), 32'd15);
        wait_halt_drain("run");
        chk("halt_imem_addr", 32'(bus.imem_addr), 32'd16);

        // Redirect out of halt restarts the stream.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'h00;
        tick();
        bus.redirect_valid = 1'b0;
        chk("unhalt_halted", 32'(bus.halted), 32'd0);
        chk("unhalt_valid", 32'(bus.out_valid), 32'd0);
        push_range(8'h00, 16);
        wait_halt_drain("unhalt");

        // Backpressure: FIFO saturates at 4 entries.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        push_range(8'h00, 16);
        repeat (8) tick();
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_head_pc", 32'(bus.out_pc), 32'd0);
        chk("bp_imem_addr", 32'(bus.imem_addr), 32'd4);
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_pc", 32'(bus.out_pc), 32'd1);
        wait_halt_drain("bp");

        // Full FIFO, ready every other cycle: one fetch per pop.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        push_range(8'h00, 16);
        repeat (6) tick();
        for (int i = 0; i < 8; i++) begin
            bus.out_ready = (i % 2 == 0);
            tick();
            chk("full_addr_lead", 32'(bus.imem_addr), 32'(8'(bus.out_pc + 8'd4)));
        end
        bus.out_ready = 1'b1;
        wait_halt_drain("alt");

        // Redirect with 3 queued entries; the same-cycle pop still counts.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        push_range(8'h00, 1);
        repeat (3) tick();
        chk("rd_pre_addr", 32'(bus.imem_addr), 32'd3);
        bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'd12;
        tick();
        bus.redirect_valid = 1'b0;
        chk("rd_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("rd_pre_popped", 32'(exp_q.size()), 32'd0);
        push_range(8'd12, 4);
        tick();
        chk("rd_tgt_valid", 32'(bus.out_valid), 32'd1);
        chk("rd_tgt_pc", 32'(bus.out_pc), 32'd12);
        chk("rd_tgt_instr", 32'(bus.out_instr), 32'hB102);
        wait_halt_drain("redir");

        // Address wrap on zero-filled memory, then fetch_en low to stop.
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'hFE;
        tick();
        bus.redirect_valid = 1'b0;
        chk("wrap_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("wrap_addr", 32'(bus.imem_addr), 32'hFE);
        push_range(8'hFE, 4);
        repeat (4) tick();
        bus.fetch_en = 1'b0;
        repeat (6) tick();
        chk("wrap_drained", 32'(bus.out_valid), 32'd0);
        chk("wrap_hold_addr", 32'(bus.imem_addr), 32'h02);
        chk("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-stream with a full FIFO and a competing redirect.
        load_prog();
        bus.fetch_en = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b0;
        repeat (6) tick();
        chk("full_valid", 32'(bus.out_valid), 32'd1);
        chk("full_addr", 32'(bus.imem_addr), 32'd4);
        rst = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 8'd5;
        tick();
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_addr", 32'(bus.imem_addr), 32'd0);
        chk("midrst_halted", 32'(bus.halted), 32'd0);
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        tick();
        chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
        chk("post_rst_pc", 32'(bus.out_pc), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
